// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: frames a parallel word as preamble + MSB-first payload + idle-level guard gap on one serial line
module serial_pattern_tx #(
    parameter int               DATA_W     = 8,
    parameter int               PRE_W      = 4,
    parameter logic [PRE_W-1:0] PREAMBLE   = 4'b1011,
    parameter int               GAP_CYC    = 2,
    parameter logic             IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    output logic              data_out,
    output logic              busy,
    output logic              frame_done
);
    localparam int M1 = (PRE_W > DATA_W) ? PRE_W : DATA_W;
    localparam int M2 = (M1 > GAP_CYC) ? M1 : GAP_CYC;
    localparam int MX = (M2 > 2) ? M2 : 2;
    localparam int CW = $clog2(MX);
    localparam int SW = PRE_W + DATA_W;
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_W - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [SW-1:0]   sr, sr_n;
    logic            data_n, last_pre, last_data, last_gap, fin, accept;

    // Preamble and payload share one shift register so the serial bit is always its MSB
    always_comb begin
        last_pre   = (state == PRE) && (cnt == PRE_LAST);
        last_data  = (state == DATA) && (cnt == DATA_LAST);
        last_gap   = (state == GAP) && (cnt == GAP_LAST);
        fin        = (GAP_CYC == 0) ? last_data : last_gap;
        load_ready = (state == IDLE) || fin;
        busy       = (state != IDLE);
        frame_done = fin;
        accept     = load_valid && load_ready;
        state_n    = accept ? PRE : fin ? IDLE : last_pre ? DATA : last_data ? GAP : state;
        cnt_n      = (state_n != state || state == IDLE) ? '0 : cnt + CW'(1);
        sr_n       = accept ? {PREAMBLE, load_data} : (state == PRE || state == DATA) ? sr << 1 : sr;
        data_n     = (state_n == PRE || state_n == DATA) ? sr_n[SW-1] : IDLE_LEVEL;
    end

    // State, counter, shift register and the registered serial output
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            sr       <= '0;
            data_out <= IDLE_LEVEL;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            sr       <= sr_n;
            data_out <= data_n;
        end
    end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: drives a default instance and a short no-gap instance against a frame-position reference model
module tb_serial_pattern_tx;
    localparam int L0 = 14;
    localparam int L1 = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       v0, v1;
    logic [7:0] d0;
    logic [3:0] d1;
    logic       rdy0, out0, busy0, done0;
    logic       rdy1, out1, busy1, done1;

    int         pos0 = -1, pos1 = -1;
    logic [7:0] w0 = '0, w1 = '0;
    int         n_chk = 0, n_fail = 0;

    serial_pattern_tx dut0 (
        .clk(clk), .reset(reset), .load_valid(v0), .load_ready(rdy0), .load_data(d0),
        .data_out(out0), .busy(busy0), .frame_done(done0)
    );

    serial_pattern_tx #(.DATA_W(4), .GAP_CYC(0)) dut1 (
        .clk(clk), .reset(reset), .load_valid(v1), .load_ready(rdy1), .load_data(d1),
        .data_out(out1), .busy(busy1), .frame_done(done1)
    );

    always #5 clk = ~clk;

    function automatic logic exp_bit(input int pos, input logic [7:0] w, input int dw);
        logic [3:0] p;
        p = 4'b1011;
        if (pos < 0) return 1'b0;
        if (pos < 4) return p[3-pos];
        if (pos < 4 + dw) return w[dw-1-(pos-4)];
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic a_v, input logic [7:0] a_d,
                        input logic b_v, input logic [3:0] b_d);
        logic a0, a1;
        reset = r; v0 = a_v; d0 = a_d; v1 = b_v; d1 = b_d;
        a0 = a_v && (pos0 < 0 || pos0 == L0 - 1);
        a1 = b_v && (pos1 < 0 || pos1 == L1 - 1);
        @(posedge clk);
        if (!r && a0) w0 = a_d;
        if (!r && a1) w1 = {4'b0, b_d};
        pos0 = r ? -1 : a0 ? 0 : (pos0 == L0 - 1) ? -1 : (pos0 >= 0) ? pos0 + 1 : -1;
        pos1 = r ? -1 : a1 ? 0 : (pos1 == L1 - 1) ? -1 : (pos1 >= 0) ? pos1 + 1 : -1;
        #1;
        chk("dut0.data_out", out0, exp_bit(pos0, w0, 8));
        chk("dut0.busy", busy0, pos0 >= 0);
        chk("dut0.load_ready", rdy0, pos0 < 0 || pos0 == L0 - 1);
        chk("dut0.frame_done", done0, pos0 == L0 - 1);
        chk("dut1.data_out", out1, exp_bit(pos1, w1, 4));
        chk("dut1.busy", busy1, pos1 >= 0);
        chk("dut1.load_ready", rdy1, pos1 < 0 || pos1 == L1 - 1);
        chk("dut1.frame_done", done1, pos1 == L1 - 1);
    endtask

    initial begin
        reset = 1'b1; v0 = 1'b0; d0 = '0; v1 = 1'b0; d1 = '0;
        step(1, 0, 8'h00, 0, 4'h0);
        step(1, 0, 8'h00, 0, 4'h0);
        for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 0, 4'h0);
        step(0, 1, 8'hA5, 1, 4'h9);
        for (int i = 0; i < 16; i++) step(0, 0, 8'h5A, 0, 4'h6);
        step(0, 1, 8'h3C, 0, 4'h0);
        for (int i = 0; i < 14; i++) step(0, 1, 8'hFF, 1, 4'hF);
        for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 0, 4'h0);
        step(0, 1, 8'hA5, 1, 4'h3);
        for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 0, 4'h0);
        step(0, 1, 8'hFF, 1, 4'hF);
        for (int i = 0; i < 7; i++) step(0, 0, 8'h00, 0, 4'h0);
        step(1, 0, 8'h00, 0, 4'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 4'h0);
        step(0, 1, 8'h5A, 1, 4'hA);
        for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 0, 4'h0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0, 8'($urandom),
                 $urandom_range(0, 2) == 0, 4'($urandom));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
